// File: rtl/sar_search_ctrl_pkg.sv
// sar_search_ctrl_pkg: shared state encoding, flag indices and width helper for the SAR search controller
package sar_search_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam int FLAG_GT = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 2;
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sar_search_ctrl_if.sv
// sar_search_ctrl_if: request/result handshake plus comparator operand/flags; flag_err only with SAR_SEARCH_FLAGCHK_EN
interface sar_search_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic [WIDTH-1:0] probe;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             exact;
`ifdef SAR_SEARCH_FLAGCHK_EN
    logic             flag_err;
    modport master (output start, cmp_gt, cmp_lt, cmp_eq, input probe, busy, done, result, exact, flag_err);
    modport slave  (input start, cmp_gt, cmp_lt, cmp_eq, output probe, busy, done, result, exact, flag_err);
`else
    modport master (output start, cmp_gt, cmp_lt, cmp_eq, input probe, busy, done, result, exact);
    modport slave  (input start, cmp_gt, cmp_lt, cmp_eq, output probe, busy, done, result, exact);
`endif
endinterface

// File: rtl/sar_settle_timer.sv
// sar_settle_timer: loadable down-counter that stops at zero and flags when the comparator has settled
module sar_settle_timer import sar_search_ctrl_pkg::*; #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);
    localparam int CW = clog2_min1(SETTLE_CYCLES + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= CW'(SETTLE_CYCLES);
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl: MSB-first successive-approximation search over an external comparator; SAR_SEARCH_FLAGCHK_EN adds flag one-hot checking
module sar_search_ctrl import sar_search_ctrl_pkg::*; #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    sar_search_ctrl_if.slave bus
);
    localparam int IW = clog2_min1(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] probe, probe_n, result, result_n, upd;
    logic [IW-1:0]    idx, idx_n;
    logic             busy, busy_n, done, done_n, exact, exact_n, load, zero;
    logic [2:0]       flags;
`ifdef SAR_SEARCH_FLAGCHK_EN
    logic             err, err_n;
    assign bus.flag_err = err;
`endif
    assign flags[FLAG_GT] = bus.cmp_gt;
    assign flags[FLAG_LT] = bus.cmp_lt;
    assign flags[FLAG_EQ] = bus.cmp_eq;
    sar_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(load), .zero(zero)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            probe  <= '0;
            result <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            exact  <= 1'b0;
`ifdef SAR_SEARCH_FLAGCHK_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            probe  <= probe_n;
            result <= result_n;
            idx    <= idx_n;
            busy   <= busy_n;
            done   <= done_n;
            exact  <= exact_n;
`ifdef SAR_SEARCH_FLAGCHK_EN
            err    <= err_n;
`endif
        end
    // gt keeps the trial bit, anything else (lt or no flag) clears it
    always_comb begin
        state_n  = state;
        probe_n  = probe;
        result_n = result;
        idx_n    = idx;
        busy_n   = busy;
        done_n   = 1'b0;
        exact_n  = exact;
        load     = 1'b0;
        upd      = probe;
        upd[idx] = flags[FLAG_GT];
`ifdef SAR_SEARCH_FLAGCHK_EN
        err_n    = err;
`endif
        if (bus.start && state != WAIT) begin
            state_n = WAIT;
            probe_n = WIDTH'(1) << (WIDTH - 1);
            idx_n   = IW'(WIDTH - 1);
            load    = 1'b1;
            busy_n  = 1'b1;
            exact_n = 1'b0;
`ifdef SAR_SEARCH_FLAGCHK_EN
            err_n   = 1'b0;
`endif
        end else if (state == WAIT && zero) begin
`ifdef SAR_SEARCH_FLAGCHK_EN
            if (!$onehot(flags)) begin
                state_n  = DONE;
                result_n = '0;
                exact_n  = 1'b0;
                err_n    = 1'b1;
                busy_n   = 1'b0;
                done_n   = 1'b1;
            end else
`endif
            if (flags[FLAG_EQ]) begin
                state_n  = DONE;
                result_n = probe;
                exact_n  = 1'b1;
                busy_n   = 1'b0;
                done_n   = 1'b1;
            end else if (idx == '0) begin
                state_n  = DONE;
                result_n = upd;
                busy_n   = 1'b0;
                done_n   = 1'b1;
            end else begin
                probe_n = upd | (WIDTH'(1) << (idx - 1'b1));
                idx_n   = idx - 1'b1;
                load    = 1'b1;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    assign bus.probe  = probe;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.exact  = exact;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// tb_sar_search_ctrl: directed vectors against a behavioural comparator driven by target and probe
module tb_sar_search_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_bad = 1'b0;
    int target = 0;
    int checks = 0;
    int failures = 0;
    int n;
    logic [3:0] trace [0:63];

    sar_search_ctrl_if #(.WIDTH(4)) bus();
    sar_search_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    assign bus.cmp_gt = force_bad | (target > int'(bus.probe));
    assign bus.cmp_lt = force_bad | (target < int'(bus.probe));
    assign bus.cmp_eq = !force_bad && (target == int'(bus.probe));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
            trace[cyc] = bus.probe;
        end while (!bus.done && cyc < 60);
    endtask

    task automatic start_search(input int t);
        target = t;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_probe", 32'(bus.probe), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_exact", 32'(bus.exact), 0);
        rst_n = 1'b1;
        step();

        start_search(11);
        check("t11_busy", 32'(bus.busy), 1);
        check("t11_probe0", 32'(bus.probe), 8);
        wait_done(n);
        check("t11_cycles", 32'(n), 8);
        check("t11_probe1", 32'(trace[2]), 12);
        check("t11_probe2", 32'(trace[4]), 10);
        check("t11_probe3", 32'(trace[6]), 11);
        check("t11_result", 32'(bus.result), 11);
        check("t11_exact", 32'(bus.exact), 1);
        check("t11_busy_end", 32'(bus.busy), 0);
        step();
        check("t11_done_pulse", 32'(bus.done), 0);
        check("t11_result_hold", 32'(bus.result), 11);

        start_search(8);
        wait_done(n);
        check("t8_cycles", 32'(n), 2);
        check("t8_result", 32'(bus.result), 8);
        check("t8_exact", 32'(bus.exact), 1);
        step();

        start_search(0);
        wait_done(n);
        check("t0_cycles", 32'(n), 8);
        check("t0_probe3", 32'(trace[6]), 1);
        check("t0_result", 32'(bus.result), 0);
        check("t0_exact", 32'(bus.exact), 0);
        step();

        start_search(15);
        wait_done(n);
        check("t15_cycles", 32'(n), 8);
        check("t15_result", 32'(bus.result), 15);
        check("t15_exact", 32'(bus.exact), 1);
        step();

        start_search(9);
        step();
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("mid_start_probe", 32'(bus.probe), 12);
        check("mid_start_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_probe", 32'(bus.probe), 0);
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_result", 32'(bus.result), 0);
        check("arst_exact", 32'(bus.exact), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_search(5);
        wait_done(n);
        check("t5_cycles", 32'(n), 8);
        check("t5_result", 32'(bus.result), 5);
        check("t5_exact", 32'(bus.exact), 1);
        step();

`ifdef SAR_SEARCH_FLAGCHK_EN
        force_bad = 1'b1;
        start_search(5);
        wait_done(n);
        check("err_cycles", 32'(n), 2);
        check("err_result", 32'(bus.result), 0);
        check("err_exact", 32'(bus.exact), 0);
        check("err_flag", 32'(bus.flag_err), 1);
        step();
        check("err_sticky", 32'(bus.flag_err), 1);
        force_bad = 1'b0;
        start_search(5);
        check("err_cleared", 32'(bus.flag_err), 0);
        wait_done(n);
        check("err_recover", 32'(bus.result), 5);
        step();
`endif

        target = 6;
        bus.start = 1'b1;
        step();
        wait_done(n);
        check("b2b_t6_cycles", 32'(n), 6);
        check("b2b_t6_result", 32'(bus.result), 6);
        target = 3;
        step();
        bus.start = 1'b0;
        check("b2b_done_drop", 32'(bus.done), 0);
        check("b2b_busy", 32'(bus.busy), 1);
        check("b2b_probe", 32'(bus.probe), 8);
        check("b2b_result_hold", 32'(bus.result), 6);
        wait_done(n);
        check("b2b_t3_cycles", 32'(n), 8);
        check("b2b_t3_result", 32'(bus.result), 3);
        check("b2b_t3_exact", 32'(bus.exact), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
